// File: rtl/axi_rom_reader.sv
// ---------------------------------------------------------------------------
// axi_rom_reader
//
// Purpose:
//   Walks a contiguous word range of the ROM behind axi_rom_ctrl using
//   single-beat AXI4-Lite reads, one outstanding at a time. The fetched words
//   are streamed out on AXI4-Stream through a 2-entry FIFO. The last word of
//   a run carries tlast.
//
// Configuration macro:
//   AXI_ROM_READER_RRESP_CHECK_EN
//     Defined:   a non-OKAY rresp sets err_o. That beat closes the frame with
//                tlast and the run ends. err_o clears on the next accepted
//                start.
//     Undefined: rresp is ignored and err_o is tied to 0.
//
// Ports:
//   axi_clk, axi_s_rst_n        clock, asynchronous active-low reset
//   start_i, base_addr_i, len_i request (sampled only in IDLE)
//   busy_o, done_o, err_o       status (done_o is a one-cycle pulse)
//   m_axi_ar*, m_axi_r*         AXI4-Lite read master channels
//   m_axis_t*                   AXI4-Stream master
//   dbg_state                   current FSM state, for debug and checkers
//
// Handshakes: every channel uses strict valid/ready semantics. A transfer
// happens on a rising edge where valid and ready are both high. Once valid
// is raised, it and its payload stay stable until that transfer. Valid
// never depends combinationally on ready.
// ---------------------------------------------------------------------------
module axi_rom_reader #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 4,
    parameter int LEN_WIDTH      = 8,
    parameter int ADDR_STEP      = 1
) (
    input  logic                      axi_clk,
    input  logic                      axi_s_rst_n,
    input  logic                      start_i,
    input  logic [AXI_ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]      len_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [2:0]                dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_INC = AXI_ADDR_WIDTH'(ADDR_STEP);
    localparam logic [LEN_WIDTH-1:0]      LEN_ONE  = LEN_WIDTH'(1);

    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]      remain;
    logic                      arvalid_q;
    logic                      busy_q;
    logic                      done_q;

    // 2-entry FIFO between the R channel and the stream
    logic [AXI_DATA_WIDTH-1:0] fifo_data [2];
    logic                      fifo_last [2];
    logic                      wr_ptr;
    logic                      rd_ptr;
    logic [1:0]                fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      r_fire;
    logic                      rresp_bad;
    logic                      last_beat;
    logic                      full_after_push;

    assign fifo_full  = (fifo_count == 2'd2);
    assign fifo_empty = (fifo_count == 2'd0);

    assign m_axi_rready = (state == S_DATA) && !fifo_full;
    assign r_fire       = m_axi_rvalid && m_axi_rready;
    assign push         = r_fire;
    assign pop          = !fifo_empty && m_axis_tready;

    // A failed read ends the frame just like the final word.
    assign last_beat = (remain == LEN_ONE) || rresp_bad;

    // The FIFO only fills when nothing pops on this edge. In that case the
    // next read request is held back until a slot frees. This way the
    // controller is never handed a read whose data we could not accept.
    assign full_after_push = (fifo_count == 2'd1) && !pop;

`ifdef AXI_ROM_READER_RRESP_CHECK_EN
    logic err_q;

    assign rresp_bad = (m_axi_rresp != 2'b00);

    always_ff @(posedge axi_clk or negedge axi_s_rst_n) begin
        if (!axi_s_rst_n) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE && start_i) begin
            err_q <= 1'b0;
        end else if (r_fire && rresp_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_rresp;

    assign unused_rresp = ^m_axi_rresp;
    assign rresp_bad    = 1'b0;
    assign err_o        = 1'b0;
`endif

    // FIFO storage and pointers
    always_ff @(posedge axi_clk or negedge axi_s_rst_n) begin
        if (!axi_s_rst_n) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_data[wr_ptr] <= m_axi_rdata;
                fifo_last[wr_ptr] <= last_beat;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sequencer
    always_ff @(posedge axi_clk or negedge axi_s_rst_n) begin
        if (!axi_s_rst_n) begin
            state     <= S_IDLE;
            addr      <= '0;
            remain    <= '0;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (len_i != '0) begin
                            addr      <= base_addr_i;
                            remain    <= len_i;
                            arvalid_q <= 1'b1;
                            state     <= S_ADDR;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_ADDR: begin
                    if (arvalid_q && m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= S_DATA;
                    end else if (!arvalid_q && !fifo_full) begin
                        arvalid_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_fire) begin
                        remain <= remain - LEN_ONE;
                        addr   <= addr + ADDR_INC;
                        if (last_beat) begin
                            state <= S_DRAIN;
                        end else begin
                            arvalid_q <= !full_after_push;
                            state     <= S_ADDR;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign m_axi_araddr  = addr;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign m_axis_tdata  = fifo_data[rd_ptr];
    assign m_axis_tlast  = fifo_last[rd_ptr];
    assign m_axis_tvalid = !fifo_empty;
    assign dbg_state     = state;

endmodule

// File: tb/tb_axi_rom_reader.sv
// ---------------------------------------------------------------------------
// tb_axi_rom_reader
//
// Bench for axi_rom_reader. A ROM-controller responder and a stream sink run
// on the falling edge. Each transaction is predicted from its (base, len,
// failing beat): the list of read addresses and the list of stream words are
// compared with what was observed on the buses.
// Also honours AXI_ROM_READER_RRESP_CHECK_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axi_rom_reader;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int LW = 8;

    // ---------------- clock / reset ----------------
    logic          axi_clk = 1'b0;
    logic          axi_s_rst_n;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic [LW-1:0] len_i;
    logic          busy_o, done_o, err_o;
    logic [AW-1:0] m_axi_araddr;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid, m_axi_arready;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rvalid, m_axi_rready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
    logic [2:0]    dbg_state;

    always #5 axi_clk = ~axi_clk;

    axi_rom_reader #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .ADDR_STEP(1)
    ) dut (
        .axi_clk(axi_clk), .axi_s_rst_n(axi_s_rst_n),
        .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;

    logic [DW-1:0] rom [16];
    logic [AW-1:0] exp_ar_q[$];
    logic [DW:0]   exp_q[$];        // {tlast, tdata}
    logic [AW-1:0] ar_log[$];
    logic [DW:0]   got_q[$];
    bit            exp_err;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // ---------------- responder / sink ----------------
    localparam int P_AR = 0, P_RWAIT = 1, P_RVALID = 2;
    int            phase = P_AR;
    int            r_delay = 0;
    int            tready_mode = 1;   // 0 hold low, 1 always high, 2 random
    int            err_beat = 0;
    int            r_beats = 0;
    logic [AW-1:0] pend_addr, pend_next;
    bit            ar_fire = 0, r_fire = 0, t_fire = 0;
    bit            pv_ar = 0, pv_t = 0;
    logic [AW-1:0] pv_araddr;
    logic [DW:0]   pv_tword, t_cap;

    task automatic bus_step();
        if (!axi_s_rst_n) begin
            phase = P_AR; ar_fire = 0; r_fire = 0; t_fire = 0; pv_ar = 0; pv_t = 0;
            m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
            m_axis_tready = 1'b0;
            return;
        end
        // payload held while a handshake was pending
        if (pv_ar) begin
            check("arvalid_held", m_axi_arvalid, 1);
            check("araddr_held", m_axi_araddr, pv_araddr);
        end
        if (pv_t) begin
            check("tvalid_held", m_axis_tvalid, 1);
            check("tword_held", {m_axis_tlast, m_axis_tdata}, pv_tword);
        end
        // retire transfers that happened on the rising edge just passed
        if (ar_fire) begin
            phase = P_RWAIT; r_delay = $urandom_range(0, 2); pend_addr = pend_next;
        end
        if (r_fire) begin
            phase = P_AR; r_beats++;
            check("tvalid_after_r", m_axis_tvalid, 1);
        end
        if (t_fire) got_q.push_back(t_cap);
        // drive
        case (phase)
            P_AR: begin
                m_axi_rvalid  = 1'b0;
                m_axi_arready = ($urandom_range(0, 3) != 0);
            end
            P_RWAIT: begin
                m_axi_arready = 1'b0;
                if (r_delay == 0) begin
                    m_axi_rvalid = 1'b1;
                    m_axi_rdata  = rom[pend_addr];
`ifdef AXI_ROM_READER_RRESP_CHECK_EN
                    m_axi_rresp  = (r_beats + 1 == err_beat) ? 2'b10 : 2'b00;
`else
                    m_axi_rresp  = 2'($urandom_range(0, 3));
`endif
                    phase = P_RVALID;
                end else begin
                    r_delay--;
                end
            end
            default: ;
        endcase
        case (tready_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        // predict transfers on the coming rising edge
        ar_fire   = m_axi_arvalid && m_axi_arready;
        if (ar_fire) begin
            ar_log.push_back(m_axi_araddr);
            pend_next = m_axi_araddr;
        end
        r_fire    = m_axi_rvalid && m_axi_rready;
        t_fire    = m_axis_tvalid && m_axis_tready;
        t_cap     = {m_axis_tlast, m_axis_tdata};
        pv_ar     = m_axi_arvalid && !m_axi_arready;
        pv_araddr = m_axi_araddr;
        pv_t      = m_axis_tvalid && !m_axis_tready;
        pv_tword  = t_cap;
    endtask

    initial begin
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
        m_axi_rresp = 2'b00; m_axis_tready = 1'b0;
        forever begin
            @(negedge axi_clk);
            bus_step();
        end
    end

    // ---------------- driver tasks ----------------
    // Reference: a run reads base, base+1, ... (mod 16). It stops after len
    // words, or after the failing beat when rresp checking is built in.
    task automatic start_txn(input logic [AW-1:0] base, input logic [LW-1:0] len, input int errb);
        int n;
        n = int'(len);
        exp_err = 1'b0;
`ifdef AXI_ROM_READER_RRESP_CHECK_EN
        if (errb >= 1 && errb <= int'(len)) begin
            n = errb;
            exp_err = 1'b1;
        end
`endif
        exp_ar_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_ar_q.push_back(AW'(int'(base) + i));
            exp_q.push_back({(i == n - 1), rom[AW'(int'(base) + i)]});
        end
        ar_log.delete(); got_q.delete(); r_beats = 0; err_beat = errb;
        start_i = 1'b1; base_addr_i = base; len_i = len;
        @(negedge axi_clk);
        start_i = 1'b0;
        if (len != '0) begin
            check("arvalid_after_start", m_axi_arvalid, 1);
            check("araddr_after_start", m_axi_araddr, base);
            check("busy_after_start", busy_o, 1);
        end
`ifdef AXI_ROM_READER_RRESP_CHECK_EN
        check("err_cleared_by_start", err_o, 0);
`endif
    endtask

    task automatic finish_txn(input string tag);
        int dones = 0;
        int cyc = 0;
        logic err_at_done = 1'b0;
        while (dones == 0 && cyc < 6000) begin
            if (done_o === 1'b1) begin
                dones++;
                err_at_done = err_o;
                check({tag, "_busy_at_done"}, busy_o, 0);
            end
            @(negedge axi_clk);
            cyc++;
        end
        repeat (4) begin
            if (done_o === 1'b1) dones++;
            @(negedge axi_clk);
        end
        check({tag, "_done_pulses"}, dones, 1);
        check({tag, "_err_at_done"}, err_at_done, exp_err);
        check({tag, "_state_idle"}, dbg_state, 0);
        check({tag, "_ar_count"}, ar_log.size(), exp_ar_q.size());
        for (int i = 0; i < exp_ar_q.size() && i < ar_log.size(); i++)
            check($sformatf("%s_ar%0d", tag, i), ar_log[i], exp_ar_q[i]);
        check({tag, "_beat_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic run_txn(input logic [AW-1:0] base, input logic [LW-1:0] len, input int errb,
                           input string tag);
        start_txn(base, len, errb);
        finish_txn(tag);
    endtask

    // ---------------- test vectors ----------------
    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        int            tmode;
        int            exp_beats;
        logic [AW-1:0] exp_last_addr;
        logic [DW-1:0] exp_last_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int guard;
        vecs[0] = '{base: 4'd2,  len: 8'd4,  tmode: 1, exp_beats: 4,  exp_last_addr: 4'd5,  exp_last_data: 32'hA5};
        vecs[1] = '{base: 4'd14, len: 8'd4,  tmode: 1, exp_beats: 4,  exp_last_addr: 4'd1,  exp_last_data: 32'hA1};
        vecs[2] = '{base: 4'd0,  len: 8'd1,  tmode: 2, exp_beats: 1,  exp_last_addr: 4'd0,  exp_last_data: 32'hA0};
        vecs[3] = '{base: 4'd15, len: 8'd16, tmode: 2, exp_beats: 16, exp_last_addr: 4'd14, exp_last_data: 32'hAE};
        vecs[4] = '{base: 4'd7,  len: 8'd0,  tmode: 1, exp_beats: 0,  exp_last_addr: 4'd0,  exp_last_data: 32'h0};
        for (int i = 0; i < 16; i++) rom[i] = 32'hA0 + 32'(i);

        start_i = 1'b0; base_addr_i = '0; len_i = '0; axi_s_rst_n = 1'b0;
        repeat (3) @(negedge axi_clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_araddr", m_axi_araddr, 0);
        check("rst_arprot", m_axi_arprot, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_state", dbg_state, 0);
        axi_s_rst_n = 1'b1;
        @(negedge axi_clk);

        // len = 0: done two cycles after start, no read traffic
        tready_mode = 1;
        start_txn(4'd7, 8'd0, 0);
        check("len0_done_early", done_o, 0);
        check("len0_arvalid", m_axi_arvalid, 0);
        @(negedge axi_clk);
        check("len0_done", done_o, 1);
        check("len0_arvalid2", m_axi_arvalid, 0);
        finish_txn("len0");

        // table
        for (int v = 0; v < 5; v++) begin
            tready_mode = vecs[v].tmode;
            run_txn(vecs[v].base, vecs[v].len, 0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_nbeats", v), got_q.size(), vecs[v].exp_beats);
            if (got_q.size() > 0 && ar_log.size() > 0) begin
                check($sformatf("vec%0d_last_addr", v), ar_log[$], vecs[v].exp_last_addr);
                check($sformatf("vec%0d_last_data", v), got_q[$][DW-1:0], vecs[v].exp_last_data);
                check($sformatf("vec%0d_last_flag", v), got_q[$][DW], 1);
            end
        end

        // stream held off: two words buffered, then reads stop
        tready_mode = 0;
        start_txn(4'd3, 8'd5, 0);
        repeat (40) @(negedge axi_clk);
        check("bp_ar_count", ar_log.size(), 2);
        check("bp_r_count", r_beats, 2);
        check("bp_rready", m_axi_rready, 0);
        check("bp_tvalid", m_axis_tvalid, 1);
        check("bp_tdata", m_axis_tdata, 32'hA3);
        check("bp_tlast", m_axis_tlast, 0);
        tready_mode = 2;
        finish_txn("bp");

`ifdef AXI_ROM_READER_RRESP_CHECK_EN
        // slave error on word 2 of 4
        tready_mode = 1;
        run_txn(4'd0, 8'd4, 2, "rerr");
        check("rerr_err_sticky", err_o, 1);
        start_txn(4'd5, 8'd1, 0);
        finish_txn("rerr_next");
`endif

        // reset while a read request is pending
        tready_mode = 0;
        start_txn(4'd9, 8'd6, 0);
        guard = 0;
        while (!(m_axi_arvalid && m_axis_tvalid) && guard < 60) begin
            @(negedge axi_clk);
            guard++;
        end
        check("rst_mid_reached_addr", guard < 60, 1);
        #2 axi_s_rst_n = 1'b0;
        #1;
        check("rst_mid_arvalid", m_axi_arvalid, 0);
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_tvalid", m_axis_tvalid, 0);
        check("rst_mid_rready", m_axi_rready, 0);
        @(negedge axi_clk);
        @(negedge axi_clk);
        #2 axi_s_rst_n = 1'b1;
        @(negedge axi_clk);
        tready_mode = 1;
        run_txn(4'd4, 8'd3, 0, "post_rst");

        // randomized runs against the reference
        for (int k = 0; k < 30; k++) begin
            logic [AW-1:0] b;
            logic [LW-1:0] l;
            int e;
            for (int i = 0; i < 16; i++) rom[i] = $urandom;
            b = AW'($urandom_range(0, 15));
            l = (k == 0) ? 8'd255 : LW'($urandom_range(0, 12));
            e = ($urandom_range(0, 1) == 1) ? $urandom_range(1, int'(l) + 2) : 0;
            tready_mode = $urandom_range(1, 2);
            run_txn(b, l, e, $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_rom_reader.md
# axi_rom_reader

Sequential AXI4-Lite read master that walks a contiguous word range of the ROM behind `axi_rom_ctrl` and streams the fetched words out on AXI4-Stream. It sits directly upstream of the ROM controller's slave read port and issues one single-beat read at a time, matching the controller's one-outstanding-read behaviour. A 2-entry FIFO decouples R-channel acceptance from downstream stream backpressure.

## Interface
- `AXI_DATA_WIDTH`, 32, data width of the R channel and of the stream.
- `AXI_ADDR_WIDTH`, 4, AR address width.
- `LEN_WIDTH`, 8, width of the word-count request.
- `ADDR_STEP`, 1, increment added to `araddr` per word. The ROM controller passes `araddr` straight through as the ROM word address.

- `axi_clk` in 1: the only clock.
- `axi_s_rst_n` in 1: reset, asynchronous assert, active-low.
- `start_i` in 1: request pulse. Sampled only in IDLE.
- `base_addr_i` in `AXI_ADDR_WIDTH`: first address. Sampled with `start_i`.
- `len_i` in `LEN_WIDTH`: number of words. Sampled with `start_i`.
- `busy_o` out 1: high from the cycle after an accepted start until `done_o`.
- `done_o` out 1: one-cycle completion pulse.
- `err_o` out 1: sticky error flag. Only functional with the macro (see Configuration).
- `m_axi_araddr` out `AXI_ADDR_WIDTH`, `m_axi_arprot` out 3 (constant 3'b000), `m_axi_arvalid` out 1, `m_axi_arready` in 1.
- `m_axi_rdata` in `AXI_DATA_WIDTH`, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1.
- `m_axis_tdata` out `AXI_DATA_WIDTH`, `m_axis_tlast` out 1, `m_axis_tvalid` out 1, `m_axis_tready` in 1.

## Operation
- State machine: IDLE, ADDR, DATA, DRAIN, DONE.
- IDLE, `start_i`=1, `len_i`≠0:
  - latch `addr`=`base_addr_i` and `remain`=`len_i`.
  - Go to ADDR.
- IDLE, `start_i`=1, `len_i`=0: go to DONE. No AXI traffic.
- `start_i` in any other state is ignored.
- ADDR:
  - `m_axi_arvalid`=1 and `m_axi_araddr`=`addr`.
  - Both held stable until `m_axi_arready`. On handshake, go to DATA.
- DATA:
  - `m_axi_rready` = FIFO not full.
  - On `rvalid`&`rready`: push {`rdata`, last = (`remain`==1)}, decrement `remain`, and set `addr` += `ADDR_STEP` (wraps mod 2^`AXI_ADDR_WIDTH`).
  - Next state is DRAIN if this was the last word, else ADDR.
- DRAIN: wait until the FIFO is empty with its final beat accepted, then go to DONE.
- DONE: `done_o`=1 for one cycle, then IDLE.
- FIFO: 2 entries. Head drives `m_axis_tdata`, `m_axis_tlast` and `m_axis_tvalid`. Simultaneous push and pop while full is not possible, because `rready` is low when full.
- Stream rule: `tdata`/`tlast` are held stable while `tvalid`&!`tready`.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - FIFO empty;
  - `err_o`=0.
- Reset mid-operation: `m_axi_arvalid`, `m_axi_rready`, `m_axis_tvalid` and `busy_o` drop asynchronously. FIFO contents are discarded.
- Start to first `arvalid`: 1 cycle (start sampled at edge N, `arvalid` high after edge N+1... i.e. visible in cycle N+1).
- R handshake to next `arvalid`: 1 cycle.
- R handshake to `tvalid`: 1 cycle.
- Best case, `tready`=1 constant and a 1-cycle `arready`: consecutive words are spaced by AR latency + R latency + 1 cycle.
- `done_o` asserts the cycle after DRAIN sees the FIFO empty. `busy_o` deasserts in the same cycle as `done_o`.
- `len_i` of 2^`LEN_WIDTH`-1 is the maximum. Address wrap past the top of the space continues from 0 silently.

## Configuration
- Macro: `AXI_ROM_READER_RRESP_CHECK_EN`.
- Defined:
  - `m_axi_rresp`≠2'b00 on an R handshake sets `err_o`.
  - The beat is pushed with `tlast`=1, which closes the frame.
  - The FSM goes to DRAIN, then DONE. No further AR is issued.
  - `err_o` clears on the next accepted `start_i`.
- Undefined: `rresp` is ignored and `err_o` is tied to 0.

## Test plan
- `base`=2, `len`=4, `tready`=1, ROM[i]=0xA0+i:
  - ARs at 2, 3, 4, 5.
  - Stream carries 0xA2..0xA5, with `tlast` only on 0xA5.
  - One `done_o` pulse.
- `len`=0 start: `done_o` pulse 2 cycles after start. No `arvalid` ever.
- `tready` held 0 with `len`=5:
  - exactly 2 R beats accepted, then `rready`=0 and no third AR handshake completes;
  - on releasing `tready`, all 5 words arrive in order.
- `base`=14, `len`=4, `AXI_ADDR_WIDTH`=4: ARs at 14, 15, 0, 1.
- With the macro, `rresp`=2'b10 on word 2 of 4:
  - 2 beats out, the second with `tlast`=1;
  - `err_o`=1, then `done_o`;
  - `err_o` clears on the next start.
- Reset asserted in ADDR with `arvalid`=1: `arvalid`, `busy_o` and `tvalid` go to 0 immediately, and the next start runs cleanly.
